// File: rtl/conv_sched.sv
// Round-robin front end sharing one fixed(8.8)->float16 converter core among NREQ requesters.
// Special-case operands 0x0000 and 0x8000 are answered directly without starting the core.
module conv_sched #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NREQ-1:0]      Req,
  input  logic [16*NREQ-1:0]   Operand,
  output logic [NREQ-1:0]      Ack,
  output logic [15:0]          Result,
  output logic                 Err,
  output logic                 Busy,
  output logic                 Cv_Start,
  output logic [15:0]          Cv_Operand,
  input  logic                 Cv_Done,
  input  logic [15:0]          Cv_Result
);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t          r_state, w_state_nx;
  logic [1:0]      r_rr_ptr, w_rr_ptr_nx;
  logic [1:0]      r_grant, w_grant_nx;
  logic            r_start_cnt, w_start_cnt_nx;
  logic [7:0]      r_wait_cnt, w_wait_cnt_nx;
  logic [15:0]     r_result, w_result_nx;
  logic [15:0]     r_cv_operand, w_cv_operand_nx;
  logic            r_err, w_err_nx;
  logic [NREQ-1:0] r_ack, w_ack_nx;
  logic            r_busy, r_cv_start, r_done_q;

  logic            w_found;
  logic [1:0]      w_pick;
  logic [2:0]      w_sum;
  logic [3:0]      w_req4;
  logic [63:0]     w_op64;
  logic [15:0]     w_pick_op;
  logic            w_edge;

  assign w_req4 = 4'(Req);
  assign w_op64 = 64'(Operand);
  assign w_edge = Cv_Done & ~r_done_q;

  // First pending request at or above the round-robin pointer, wrapping at NREQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = 2'd0;
    w_sum   = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + 3'(k);
      if (w_sum >= 3'(NREQ)) begin
        w_sum = w_sum - 3'(NREQ);
      end else begin
        w_sum = w_sum;
      end
      if (!w_found && w_req4[w_sum[1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Operand slice of the candidate winner.
  always_comb begin
    case (w_pick)
      2'd0:    w_pick_op = w_op64[15:0];
      2'd1:    w_pick_op = w_op64[31:16];
      2'd2:    w_pick_op = w_op64[47:32];
      2'd3:    w_pick_op = w_op64[63:48];
      default: w_pick_op = 16'h0000;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nx      = r_state;
    w_rr_ptr_nx     = r_rr_ptr;
    w_grant_nx      = r_grant;
    w_start_cnt_nx  = r_start_cnt;
    w_wait_cnt_nx   = r_wait_cnt;
    w_result_nx     = r_result;
    w_cv_operand_nx = r_cv_operand;
    w_err_nx        = r_err;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nx      = w_pick;
          w_cv_operand_nx = w_pick_op;
          if (w_pick_op == 16'h0000) begin
            w_result_nx = 16'h0000;
            w_state_nx  = RESP;
          end else if (w_pick_op == 16'h8000) begin
            w_result_nx = 16'hD800;
            w_state_nx  = RESP;
          end else begin
            w_start_cnt_nx = 1'b0;
            w_state_nx     = START;
          end
        end else begin
          w_state_nx = IDLE;
        end
      end
      START: begin
        if (r_start_cnt) begin
          w_wait_cnt_nx = 8'd0;
          w_state_nx    = WAIT;
        end else begin
          w_start_cnt_nx = 1'b1;
        end
      end
      WAIT: begin
        // A Done level carried over from a previous job never counts: only a fresh rise does.
        if (w_edge) begin
          w_result_nx = Cv_Result;
          w_state_nx  = RESP;
        end else if (r_wait_cnt == 8'(TIMEOUT - 1)) begin
          w_result_nx = 16'h0000;
          w_err_nx    = 1'b1;
          w_state_nx  = RESP;
        end else begin
          w_wait_cnt_nx = r_wait_cnt + 8'd1;
        end
      end
      RESP: begin
        if (r_grant == 2'(NREQ - 1)) begin
          w_rr_ptr_nx = 2'd0;
        end else begin
          w_rr_ptr_nx = r_grant + 2'd1;
        end
        w_err_nx   = 1'b0;
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // Acknowledge vector for the job about to enter RESP.
  always_comb begin
    w_ack_nx = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_ack_nx[i] = (w_state_nx == RESP) && (w_grant_nx == 2'(i));
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rr_ptr     <= 2'd0;
      r_grant      <= 2'd0;
      r_start_cnt  <= 1'b0;
      r_wait_cnt   <= 8'd0;
      r_result     <= 16'h0000;
      r_cv_operand <= 16'h0000;
      r_err        <= 1'b0;
      r_ack        <= '0;
      r_busy       <= 1'b0;
      r_cv_start   <= 1'b0;
      r_done_q     <= 1'b0;
    end else begin
      r_rr_ptr     <= w_rr_ptr_nx;
      r_grant      <= w_grant_nx;
      r_start_cnt  <= w_start_cnt_nx;
      r_wait_cnt   <= w_wait_cnt_nx;
      r_result     <= w_result_nx;
      r_cv_operand <= w_cv_operand_nx;
      r_err        <= w_err_nx;
      r_ack        <= w_ack_nx;
      r_busy       <= (w_state_nx != IDLE);
      r_cv_start   <= (w_state_nx == START);
      r_done_q     <= Cv_Done;
    end
  end

  assign Ack        = r_ack;
  assign Result     = r_result;
  assign Err        = r_err;
  assign Busy       = r_busy;
  assign Cv_Start   = r_cv_start;
  assign Cv_Operand = r_cv_operand;

endmodule

// File: tb/tb_conv_sched.sv
// Randomized bench for conv_sched: job-level reference model (grant order, latency, result)
// plus a cycle-scripted converter that drives Done/Result for each job.
module tb_conv_sched;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  logic                Clk = 1'b0;
  logic                Reset;
  logic [NREQ-1:0]     Req;
  logic [16*NREQ-1:0]  Operand;
  logic [NREQ-1:0]     Ack;
  logic [15:0]         Result;
  logic                Err;
  logic                Busy;
  logic                Cv_Start;
  logic [15:0]         Cv_Operand;
  logic                Cv_Done;
  logic [15:0]         Cv_Result;

  conv_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Operand(Operand),
    .Ack(Ack), .Result(Result), .Err(Err), .Busy(Busy),
    .Cv_Start(Cv_Start), .Cv_Operand(Cv_Operand),
    .Cv_Done(Cv_Done), .Cv_Result(Cv_Result)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int tnow = 0;
  int m_ptr = 0;

  // Per-requester job description: operand, converter answer, Done delay after Start
  // falls (0 = stuck low), cycle offset at which Req is dropped early (0 = never), stale Done.
  logic [15:0] j_op [NREQ];
  logic [15:0] j_ret [NREQ];
  int          j_dly [NREQ];
  int          j_drop [NREQ];
  bit          j_stale [NREQ];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", tag, tnow, got, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
    tnow++;
  endtask

  function automatic int pick(input logic [NREQ-1:0] p, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (p[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return 0;
  endfunction

  // Converter Done level, rel cycles after the grant cycle.
  function automatic bit done_at(input int rel, input int d, input bit st);
    if (st) return (rel <= 3) || (rel >= 6);
    if (d == 0) return 1'b0;
    return rel >= 2 + d;
  endfunction

  // Raise the requests in mask (DUT idle, at a negedge) and serve them all, checking every cycle.
  task automatic serve(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] pend, drv;
    logic [15:0] eres;
    int w, s, a;
    bit byp, eerr;
    pend = mask;
    for (int i = 0; i < NREQ; i++) Operand[16*i +: 16] = j_op[i];
    while (pend != '0) begin
      w = pick(pend, m_ptr);
      s = tnow;
      byp = (j_op[w] == 16'h0000) || (j_op[w] == 16'h8000);
      if (byp) begin
        a = s + 1; eerr = 1'b0;
        eres = (j_op[w] == 16'h8000) ? 16'hD800 : 16'h0000;
      end else if (j_stale[w]) begin
        a = s + 7; eerr = 1'b0; eres = j_ret[w];
      end else if (j_dly[w] >= 2 && j_dly[w] <= TIMEOUT) begin
        a = s + 3 + j_dly[w]; eerr = 1'b0; eres = j_ret[w];
      end else begin
        a = s + 3 + TIMEOUT; eerr = 1'b1; eres = 16'h0000;
      end
      drv = pend;
      for (int t = s; t <= a; t++) begin
        if (t > s) step();
        check_val("ack", 32'(Ack), (t == a) ? (32'd1 << w) : 32'd0);
        check_val("busy", 32'(Busy), 32'(t > s));
        check_val("cv_start", 32'(Cv_Start), 32'(!byp && (t == s + 1 || t == s + 2)));
        check_val("err", 32'(Err), (t == a) ? 32'(eerr) : 32'd0);
        if (t == s + 1) check_val("cv_operand", 32'(Cv_Operand), 32'(j_op[w]));
        if (t == a) check_val("result", 32'(Result), 32'(eres));
        if (t == s + 1) Operand[16*w +: 16] = 16'($urandom);
        if (j_drop[w] > 0 && t == s + j_drop[w]) drv[w] = 1'b0;
        Req = drv;
        Cv_Done = byp ? 1'b0 : done_at(t - s, j_dly[w], j_stale[w]);
        Cv_Result = Cv_Done ? j_ret[w] : 16'($urandom);
      end
      pend[w] = 1'b0;
      m_ptr = (w + 1) % NREQ;
      step();
      Req = pend;
      Cv_Done = 1'b0;
    end
    check_val("idle_busy", 32'(Busy), 32'd0);
    check_val("idle_ack", 32'(Ack), 32'd0);
  endtask

  task automatic set_job(input int i, input logic [15:0] op, input logic [15:0] ret, input int d);
    j_op[i] = op; j_ret[i] = ret; j_dly[i] = d; j_drop[i] = 0; j_stale[i] = 1'b0;
  endtask

  initial begin
    int s, r;
    logic [NREQ-1:0] mask;
    Reset = 1'b0; Req = '0; Operand = '0; Cv_Done = 1'b0; Cv_Result = 16'h0000;
    for (int i = 0; i < NREQ; i++) set_job(i, 16'h0100, 16'h3C00, 4);
    step(); step();
    check_val("rst_ack", 32'(Ack), 32'd0);
    check_val("rst_result", 32'(Result), 32'd0);
    check_val("rst_err", 32'(Err), 32'd0);
    check_val("rst_busy", 32'(Busy), 32'd0);
    check_val("rst_cv_start", 32'(Cv_Start), 32'd0);
    check_val("rst_cv_operand", 32'(Cv_Operand), 32'd0);
    Reset = 1'b1;
    step();

    set_job(0, 16'h0030, 16'h3200, 6);
    serve(2'b01);

    set_job(0, 16'h0001, 16'h2000, 5);
    set_job(1, 16'hFFFF, 16'hA000, 3);
    serve(2'b11);
    set_job(0, 16'h0203, 16'h4100, 2);
    set_job(1, 16'h7F00, 16'h57F0, 9);
    serve(2'b11);

    set_job(0, 16'h8000, 16'h1111, 4);
    serve(2'b01);
    set_job(1, 16'h0000, 16'h2222, 4);
    serve(2'b10);

    set_job(0, 16'h0400, 16'h4400, 4);
    set_job(1, 16'h0500, 16'h4500, 4);
    j_stale[1] = 1'b1;
    serve(2'b11);
    j_stale[1] = 1'b0;

    set_job(0, 16'h1234, 16'h5555, 0);
    serve(2'b01);
    set_job(1, 16'h1234, 16'h6666, TIMEOUT);
    serve(2'b10);

    // Reset pulse while the job sits in WAIT: outputs clear at once and no Ack follows.
    set_job(0, 16'h1234, 16'h7777, 6);
    Operand[15:0] = j_op[0];
    s = tnow;
    for (int t = s; t <= s + 5; t++) begin
      if (t > s) step();
      Req = 2'b01;
      Cv_Done = 1'b0;
    end
    Reset = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(Busy), 32'd0);
    check_val("mid_rst_cv_start", 32'(Cv_Start), 32'd0);
    check_val("mid_rst_ack", 32'(Ack), 32'd0);
    check_val("mid_rst_cv_operand", 32'(Cv_Operand), 32'd0);
    step();
    Reset = 1'b1;
    Req = '0;
    m_ptr = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      check_val("post_rst_ack", 32'(Ack), 32'd0);
      check_val("post_rst_busy", 32'(Busy), 32'd0);
      Cv_Done = (k >= 2 && k < 6);
    end
    Cv_Done = 1'b0;
    step();
    set_job(0, 16'h0030, 16'h3200, 6);
    serve(2'b01);

    for (int e = 0; e < 40; e++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        r = $urandom_range(0, 5);
        set_job(i, (r == 0) ? 16'h0000 : (r == 1) ? 16'h8000 : 16'($urandom),
                16'($urandom), $urandom_range(2, TIMEOUT + 2));
        if ($urandom_range(0, 3) == 0) j_drop[i] = 2;
      end
      serve(mask);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
